// File: rtl/bg_pkg.sv
// Shared definitions for the bandgap lock filter: code width, FSM state type
// and the absolute-difference helper used by the lock comparison.
package bg_pkg;

  localparam int BG_CODE_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    AVG   = 2'd2,
    CMP   = 2'd3
  } bg_state_e;

  function automatic logic [BG_CODE_W-1:0] abs_diff(input logic [BG_CODE_W-1:0] a,
                                                     input logic [BG_CODE_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bg_watchdog.sv
// Sample-gap watchdog: counts cycles since the last sample edge and raises a
// sticky timeout flag. Only built when BG_LOCK_TIMEOUT_EN is defined.
`ifdef BG_LOCK_TIMEOUT_EN
module bg_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // The count parks at LIMIT so the flag stays set without wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LIMIT - 1'b1) timeout <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bg_lock_filter.sv
// Windowed averaging and lock detection on bandgap SAR trim results.
// Optional sample-gap watchdog enabled by defining BG_LOCK_TIMEOUT_EN.
module bg_lock_filter
  import bg_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pwrup,
  input  logic                 valid_in,
  input  logic [7:0]           idac_coarse,
  input  logic [7:0]           idac_fine,
  output logic [BG_CODE_W-1:0] out_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 locked,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int ACC_W  = BG_CODE_W + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam logic [SCNT_W-1:0]    WIN_CNT = SCNT_W'(1 << AVG_LOG2);
  localparam logic [BG_CODE_W-1:0] TOL     = BG_CODE_W'(LOCK_TOL);
  localparam logic [3:0]           LCNT    = 4'(LOCK_CNT);

  bg_state_e             state;
  logic [ACC_W-1:0]      acc, acc_inc;
  logic [SCNT_W-1:0]     scnt, scnt_inc;
  logic [BG_CODE_W-1:0]  avg, prev_avg, sample_code;
  logic [3:0]            mcnt, mcnt_next;
  logic                  has_prev, valid_prev, sample, locked_q;
  logic                  unused_fine_lsbs;

  assign sample_code      = {idac_coarse, idac_fine[7:4]};
  assign sample           = valid_in & ~valid_prev;
  assign unused_fine_lsbs = ^idac_fine[3:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_inc   = acc + (sample ? ACC_W'(sample_code) : '0);
    scnt_inc  = scnt + SCNT_W'(sample);
    mcnt_next = '0;
    if (has_prev && (abs_diff(avg, prev_avg) <= TOL))
      mcnt_next = (mcnt >= LCNT) ? LCNT : mcnt + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      scnt       <= '0;
      avg        <= '0;
      prev_avg   <= '0;
      mcnt       <= '0;
      has_prev   <= 1'b0;
      valid_prev <= 1'b0;
      out_code   <= '0;
      out_valid  <= 1'b0;
      locked_q   <= 1'b0;
      overrun    <= 1'b0;
    end else if (!pwrup) begin
      state      <= IDLE;
      acc        <= '0;
      scnt       <= '0;
      mcnt       <= '0;
      has_prev   <= 1'b0;
      valid_prev <= 1'b0;
      out_valid  <= 1'b0;
      locked_q   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid_prev <= valid_in;
      overrun    <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          acc  <= acc_inc;
          scnt <= scnt_inc;
          if (scnt_inc == WIN_CNT) state <= AVG;
        end
        AVG: begin
          avg   <= BG_CODE_W'(acc >> AVG_LOG2);
          // A sample landing on the clear cycle opens the next window.
          acc   <= sample ? ACC_W'(sample_code) : '0;
          scnt  <= SCNT_W'(sample);
          state <= CMP;
        end
        CMP: begin
          mcnt      <= mcnt_next;
          locked_q  <= (mcnt_next >= LCNT);
          prev_avg  <= avg;
          has_prev  <= 1'b1;
          out_code  <= avg;
          out_valid <= 1'b1;
          overrun   <= out_valid & ~out_ready;
          acc       <= acc_inc;
          scnt      <= scnt_inc;
          state     <= (scnt_inc == WIN_CNT) ? AVG : ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BG_LOCK_TIMEOUT_EN
  bg_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (pwrup),
    .restart (sample),
    .timeout (timeout)
  );
  assign locked = locked_q & ~timeout;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign locked  = locked_q;
`endif

endmodule

// File: doc/bg_lock_filter.md
# bg_lock_filter

Post-processing stage downstream of the bandgap SAR trim controller. Captures each completed conversion (the coarse IDAC code plus the top nibble of the fine IDAC code) on the rising edge of the controller's `valid`, averages a window of conversions, and tracks the change between consecutive window averages to declare lock. Results go to the trim/readout logic over a valid/ready handshake.

## Interface
- `AVG_LOG2`, 2: log2 of the window length in samples; range 0..4.
- `LOCK_TOL`, 1: maximum |avg − prev_avg| (LSB of the 12-bit code) that counts as a match.
- `LOCK_CNT`, 3: number of consecutive matches required to assert `locked`; range 1..15.
- `TIMEOUT_CYC`, 1024: watchdog limit in clk cycles; used only with `BG_LOCK_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock (10 MHz nominal).
- `reset_n`  in  1  asynchronous, active-low reset.
- `pwrup`  in  1  block enable; low clears the block synchronously.
- `valid_in`  in  1  SAR result-valid level; multi-cycle high.
- `idac_coarse`  in  8  SAR coarse code.
- `idac_fine`  in  8  SAR fine code; only bits [7:4] are used.
- `out_code`  out  12  latest window average.
- `out_valid`  out  1  `out_code` pending.
- `out_ready`  in  1  consumer accepts `out_code`.
- `locked`  out  1  lock achieved.
- `overrun`  out  1  one-cycle pulse: an unaccepted result was overwritten.
- `timeout`  out  1  sticky flag: no sample arrived within `TIMEOUT_CYC`.

## Operation
- Sample code = {idac_coarse, idac_fine[7:4]}, 12 bits. A sample is taken on the cycle where `valid_in`=1 and the registered previous `valid_in`=0.
- FSM states:
  - IDLE: entered on reset and whenever `pwrup`=0. Goes to ACCUM when `pwrup`=1.
  - ACCUM: `acc` += sample; `scnt` increments. When `scnt` reaches 2^AVG_LOG2, go to AVG.
  - AVG: `avg` ← `acc` >> AVG_LOG2 (truncating); clear `acc` and `scnt`. Go to CMP.
  - CMP: compute |avg − prev_avg| and update the match counter; `prev_avg` ← `avg`; load `out_code` and set `out_valid`. Go to ACCUM.
- Accumulator width is 12+AVG_LOG2; no overflow is possible.
- Lock rules:
  - The first window after IDLE has no previous average, so `mcnt`=0.
  - On a match, `mcnt` increments and saturates at LOCK_CNT. On a mismatch, `mcnt`=0.
  - `locked` = (`mcnt` ≥ LOCK_CNT), registered in CMP.
- Handshake:
  - `out_valid` stays high until a clock edge where `out_ready`=1, then clears.
  - If CMP loads a new result while `out_valid`=1 and `out_ready`=0, the new code overwrites the old one and `overrun` pulses for one cycle.
  - If `out_ready`=1 and a CMP load occur in the same cycle, the new load wins: `out_valid` stays 1 and there is no overrun.
- A sample edge that coincides with the clear in AVG starts the new window: `acc` = sample, `scnt` = 1.
- `pwrup`=0 clears `acc`, `scnt`, `mcnt`, the prev-valid flag, `out_valid`, `locked` and `timeout`, and puts the FSM in IDLE. `out_code` is held.

## Timing
- Reset values: `out_code`=0, `out_valid`=0, `locked`=0, `overrun`=0, `timeout`=0, state=IDLE.
- Latency: the window-closing sample edge at cycle N gives the AVG register update at N+1 and `out_valid`/`out_code`/`locked` at N+2.
- Asserting `reset_n` mid-window discards the partial window immediately.

## Configuration
- `BG_LOCK_TIMEOUT_EN` defined:
  - A watchdog counts clk cycles since the last sample edge while `pwrup`=1.
  - When the count reaches `TIMEOUT_CYC`, `timeout` is set (sticky) and `locked` is forced to 0.
  - A sample edge restarts the count but does not clear `timeout`.
- Undefined: `timeout` is tied to 0 and no counter is built.

## Structure
- Shared package `bg_pkg` holds:
  - The FSM state enum (IDLE, ACCUM, AVG, CMP).
  - `BG_CODE_W`=12.
- Sub-module `bg_watchdog` (counter plus sticky flag), instantiated only under `BG_LOCK_TIMEOUT_EN`.

## Test plan
- Four samples with coarse 0x5A and fine 0x30 -> `out_code`=0x5A3 and `out_valid`=1 two cycles after the 4th edge; `locked`=0.
- Samples 0x100, 0x101, 0x101, 0x101 -> `out_code`=0x100 (truncated).
- Four identical windows -> `locked`=1 after the 4th CMP; a following window at +2 LSB -> `locked`=0 and `mcnt`=0.
- Hold `out_ready`=0 across two windows -> one-cycle `overrun` pulse and `out_code` = second average; then `out_ready`=1 for one cycle -> `out_valid`=0.
- `reset_n` low, or `pwrup` low, after 2 samples -> partial window is discarded; the next 4 samples give an average of those 4 only.
- With `BG_LOCK_TIMEOUT_EN` and `TIMEOUT_CYC`=64, stop `valid_in` -> `timeout`=1 and `locked`=0 at cycle 64; a new sample leaves `timeout`=1.
